button_event_scheduler: RTL and testbench

- Converts N already-debounced button levels into discrete press, long-press, auto-repeat and release events.
- Shares one valid/ready event channel between all buttons using round-robin arbitration.
- Sits between the per-button hysteresis debouncers and the screen/menu control logic, so downstream logic sees one event stream instead of raw levels.

---
 rtl/button_event_pkg.sv | 18 +
 rtl/button_event_fsm.sv | 113 +++++++++++
 rtl/button_event_scheduler.sv | 101 ++++++++++
 tb/tb_button_event_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared constants for the button event scheduler: event codes, per-button
// FSM state encodings and a helper for the button-index width.
package button_event_pkg;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_LONG    = 2'd1;
  localparam logic [1:0] EV_REPEAT  = 2'd2;
  localparam logic [1:0] EV_RELEASE = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_event_fsm.sv
// One button's edge detector, press/long/repeat FSM, hold counter and
// single-entry pending event slot.
module button_event_fsm
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 6000000,
  parameter int REPEAT_CYCLES = 1200000,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level,
  input  logic       grant,
  output logic       pend_valid,
  output logic [1:0] pend_type,
  output logic       ovf_set
);

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  logic             r_prev;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend_valid;
  logic [1:0]       r_pend_type;

  logic             w_rise;
  logic             w_fall;
  logic             w_gen;
  logic [1:0]       w_ev;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_rise = level & ~r_prev;
  assign w_fall = ~level & r_prev;

  // A fall is tested before the terminal count so a release always wins.
  always_comb begin
    w_gen       = 1'b0;
    w_ev        = EV_PRESS;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_gen       = 1'b1;
          w_ev        = EV_PRESS;
        end
      end
      ST_PRESSED: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_gen       = 1'b1;
          w_ev        = EV_RELEASE;
        end else if (r_cnt == LONG_TC) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
          w_gen       = 1'b1;
          w_ev        = EV_LONG;
        end else if (r_cnt < LONG_TC) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_gen       = 1'b1;
          w_ev        = EV_RELEASE;
        end else if (r_cnt == REPEAT_TC) begin
          w_cnt_nxt = '0;
          w_gen     = 1'b1;
          w_ev      = EV_REPEAT;
        end else if (r_cnt < REPEAT_TC) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= 1'b0;
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_type  <= EV_PRESS;
    end else begin
      r_prev  <= level;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_gen) begin
        r_pend_valid <= 1'b1;
        r_pend_type  <= w_ev;
      end else if (grant) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign pend_valid = r_pend_valid;
  assign pend_type  = r_pend_type;
  assign ovf_set    = w_gen & r_pend_valid & ~grant;

endmodule

// File: rtl/button_event_scheduler.sv
// Turns debounced button levels into PRESS/LONG/REPEAT/RELEASE events and
// serialises them onto one valid/ready channel with round-robin arbitration.
module button_event_scheduler
  import button_event_pkg::*;
#(
  parameter int N_BUTTONS     = 4,
  parameter int LONG_CYCLES   = 6000000,
  parameter int REPEAT_CYCLES = 1200000,
  parameter int CNT_W         = $clog2((LONG_CYCLES > REPEAT_CYCLES) ?
                                       LONG_CYCLES : REPEAT_CYCLES) + 1,
  localparam int ID_W         = id_width(N_BUTTONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_level,
  input  logic                 ovf_clear,
  input  logic                 event_ready,
  output logic                 event_valid,
  output logic [1:0]           event_type,
  output logic [ID_W-1:0]      event_id,
  output logic [N_BUTTONS-1:0] overflow
);

  logic [N_BUTTONS-1:0] w_pend_valid;
  logic [1:0]           w_pend_type [N_BUTTONS];
  logic [N_BUTTONS-1:0] w_ovf_set;
  logic [N_BUTTONS-1:0] w_grant;
  logic                 w_load;
  logic                 w_found;
  logic [ID_W-1:0]      w_gnt_idx;
  logic [ID_W-1:0]      w_cand;

  logic                 r_valid;
  logic [1:0]           r_type;
  logic [ID_W-1:0]      r_id;
  logic [ID_W-1:0]      r_last;
  logic [N_BUTTONS-1:0] r_ovf;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    button_event_fsm #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .level     (btn_level[i]),
      .grant     (w_grant[i]),
      .pend_valid(w_pend_valid[i]),
      .pend_type (w_pend_type[i]),
      .ovf_set   (w_ovf_set[i])
    );
  end

  assign w_load = ~r_valid | event_ready;

  // Search starts one past the last winner so every button gets its turn.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < N_BUTTONS; k++) begin
      w_cand = ID_W'((int'(r_last) + 1 + k) % N_BUTTONS);
      if (!w_found && w_pend_valid[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    w_grant = '0;
    if (w_load && w_found) w_grant[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_type  <= EV_PRESS;
      r_id    <= '0;
      r_last  <= ID_W'(N_BUTTONS - 1);
    end else if (w_load) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_type  <= w_pend_type[w_gnt_idx];
        r_id    <= w_gnt_idx;
        r_last  <= w_gnt_idx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf <= '0;
    else     r_ovf <= (r_ovf & {N_BUTTONS{~ovf_clear}}) | w_ovf_set;
  end

  assign event_valid = r_valid;
  assign event_type  = r_type;
  assign event_id    = r_id;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed and randomised checks of button_event_scheduler against a
// time-since-press reference model of the button event rules.
module tb_button_event_scheduler;

   localparam int N      = 4;
   localparam int LONG   = 8;
   localparam int REPEAT = 4;

   logic         clk;
   logic         rst;
   logic [N-1:0] btnLevel;
   logic         ovfClear;
   logic         eventReady;
   logic         eventValid;
   logic [1:0]   eventType;
   logic [1:0]   eventId;
   logic [N-1:0] overflow;

   int checks = 0;
   int errors = 0;

   // Reference model state: press status and elapsed edges per button.
   bit         mPressed [N];
   int         mTime    [N];
   bit         mPrev    [N];
   bit         mPendV   [N];
   logic [1:0] mPendT   [N];
   logic [N-1:0] mOvf;
   bit         mValid;
   logic [1:0] mType;
   int         mId;
   int         mLast;

   int cntPress, cntLong, cntRepeat, cntRelease;

   button_event_scheduler #(
      .N_BUTTONS    (N),
      .LONG_CYCLES  (LONG),
      .REPEAT_CYCLES(REPEAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_level  (btnLevel),
      .ovf_clear  (ovfClear),
      .event_ready(eventReady),
      .event_valid(eventValid),
      .event_type (eventType),
      .event_id   (eventId),
      .overflow   (overflow)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         mPressed[i] = 0; mTime[i] = 0; mPrev[i] = 0;
         mPendV[i] = 0; mPendT[i] = 2'd0;
      end
      mOvf = '0; mValid = 0; mType = 2'd0; mId = 0; mLast = N - 1;
   endtask

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic modelStep();
      bit load;
      int g;
      logic [1:0] gType;
      logic [N-1:0] sets;
      bit gen;
      logic [1:0] ev;
      load = !mValid || eventReady;
      g = -1;
      gType = 2'd0;
      if (load) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mLast + 1 + k) % N;
            if (g < 0 && mPendV[idx]) g = idx;
         end
      end
      if (g >= 0) gType = mPendT[g];
      sets = '0;
      for (int i = 0; i < N; i++) begin
         bit lvl;
         lvl = btnLevel[i];
         gen = 0; ev = 2'd0;
         if (!mPressed[i]) begin
            if (lvl && !mPrev[i]) begin
               gen = 1; ev = 2'd0; mPressed[i] = 1; mTime[i] = 0;
            end
         end else if (!lvl && mPrev[i]) begin
            gen = 1; ev = 2'd3; mPressed[i] = 0;
         end else begin
            mTime[i]++;
            if (mTime[i] == LONG) begin
               gen = 1; ev = 2'd1;
            end else if (mTime[i] > LONG && ((mTime[i] - LONG) % REPEAT) == 0) begin
               gen = 1; ev = 2'd2;
            end
         end
         if (gen) begin
            if (mPendV[i] && g != i) sets[i] = 1'b1;
            mPendV[i] = 1; mPendT[i] = ev;
         end else if (g == i) begin
            mPendV[i] = 0;
         end
         mPrev[i] = lvl;
      end
      mOvf = (ovfClear ? '0 : mOvf) | sets;
      if (load) begin
         if (g >= 0) begin
            mValid = 1; mType = gType; mId = g; mLast = g;
         end else begin
            mValid = 0;
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      checkEq({tag, ".valid"}, 32'(eventValid), 32'(mValid));
      if (mValid) begin
         checkEq({tag, ".type"}, 32'(eventType), 32'(mType));
         checkEq({tag, ".id"}, 32'(eventId), 32'(mId));
      end
      checkEq({tag, ".overflow"}, 32'(overflow), 32'(mOvf));
      if (eventValid) begin
         case (eventType)
            2'd0: cntPress++;
            2'd1: cntLong++;
            2'd2: cntRepeat++;
            default: cntRelease++;
         endcase
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] lvl, input logic rdy, input logic clr);
      btnLevel = lvl; eventReady = rdy; ovfClear = clr;
   endtask

   task automatic stepCycle(input string tag);
      @(posedge clk);
      if (!rst) modelStep();
      #1;
      checkOutput(tag);
   endtask

   task automatic expectEvent(input string tag, input logic [1:0] t, input int id);
      stepCycle(tag);
      checkEq({tag, ".exp_valid"}, 32'(eventValid), 32'd1);
      checkEq({tag, ".exp_type"}, 32'(eventType), 32'(t));
      checkEq({tag, ".exp_id"}, 32'(eventId), 32'(id));
   endtask

   task automatic clearCounts();
      cntPress = 0; cntLong = 0; cntRepeat = 0; cntRelease = 0;
   endtask

   // Asynchronous reset between clock edges, released away from the edge.
   task automatic doReset(input string tag);
      rst = 1'b1;
      #1;
      modelReset();
      checkEq({tag, ".valid"}, 32'(eventValid), 32'd0);
      checkEq({tag, ".type"}, 32'(eventType), 32'd0);
      checkEq({tag, ".id"}, 32'(eventId), 32'd0);
      checkEq({tag, ".overflow"}, 32'(overflow), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus('0, 1'b1, 1'b0);
      clearCounts();
      modelReset();
      #2;
      doReset("reset");
      repeat (2) stepCycle("idle");

      // Short press on button 2.
      clearCounts();
      applyStimulus(4'b0100, 1'b1, 1'b0);
      stepCycle("short.rise");
      expectEvent("short.press", 2'd0, 2);
      stepCycle("short.hold");
      applyStimulus(4'b0000, 1'b1, 1'b0);
      stepCycle("short.fall");
      expectEvent("short.release", 2'd3, 2);
      repeat (2) stepCycle("short.idle");
      checkEq("short.no_long", 32'(cntLong), 32'd0);

      // Long hold on button 1: PRESS, LONG, three REPEATs, RELEASE.
      clearCounts();
      applyStimulus(4'b0010, 1'b1, 1'b0);
      repeat (21) stepCycle("hold");
      applyStimulus(4'b0000, 1'b1, 1'b0);
      repeat (4) stepCycle("hold.fall");
      checkEq("hold.press_cnt", 32'(cntPress), 32'd1);
      checkEq("hold.long_cnt", 32'(cntLong), 32'd1);
      checkEq("hold.repeat_cnt", 32'(cntRepeat), 32'd3);
      checkEq("hold.release_cnt", 32'(cntRelease), 32'd1);

      // Simultaneous presses and round-robin order.
      doReset("rr.reset");
      applyStimulus(4'b1011, 1'b1, 1'b0);
      stepCycle("rr.rise");
      expectEvent("rr.p0", 2'd0, 0);
      expectEvent("rr.p1", 2'd0, 1);
      expectEvent("rr.p3", 2'd0, 3);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      stepCycle("rr.fall");
      expectEvent("rr.r0", 2'd3, 0);
      expectEvent("rr.r1", 2'd3, 1);
      expectEvent("rr.r3", 2'd3, 3);
      applyStimulus(4'b0010, 1'b1, 1'b0);
      stepCycle("rr.b1rise");
      expectEvent("rr.b1press", 2'd0, 1);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      stepCycle("rr.b1fall");
      expectEvent("rr.b1release", 2'd3, 1);
      stepCycle("rr.idle");
      applyStimulus(4'b1011, 1'b1, 1'b0);
      stepCycle("rr.rise2");
      expectEvent("rr.q3", 2'd0, 3);
      expectEvent("rr.q0", 2'd0, 0);
      expectEvent("rr.q1", 2'd0, 1);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      repeat (6) stepCycle("rr.drain");

      // Stall with ready low: output held, slot overwritten, overflow.
      applyStimulus(4'b0001, 1'b0, 1'b0);
      stepCycle("stall.rise");
      expectEvent("stall.press", 2'd0, 0);
      applyStimulus(4'b0000, 1'b0, 1'b0);
      stepCycle("stall.fall");
      checkEq("stall.hold_type", 32'(eventType), 32'd0);
      checkEq("stall.hold_id", 32'(eventId), 32'd0);
      applyStimulus(4'b0001, 1'b0, 1'b0);
      stepCycle("stall.rerise");
      checkEq("stall.hold_type2", 32'(eventType), 32'd0);
      checkEq("stall.ovf_set", 32'(overflow), 32'h1);
      applyStimulus(4'b0001, 1'b0, 1'b1);
      stepCycle("stall.clear");
      checkEq("stall.ovf_clr", 32'(overflow), 32'h0);
      applyStimulus(4'b0001, 1'b1, 1'b0);
      expectEvent("stall.drain", 2'd0, 0);
      stepCycle("stall.empty");

      // Reset while held with an unconsumed event, button stays held.
      applyStimulus(4'b0000, 1'b1, 1'b0);
      repeat (3) stepCycle("rst.release0");
      applyStimulus(4'b1000, 1'b0, 1'b0);
      repeat (14) stepCycle("rst.hold");
      doReset("rst.mid");
      applyStimulus(4'b1000, 1'b1, 1'b0);
      stepCycle("rst.rise");
      expectEvent("rst.press", 2'd0, 3);
      clearCounts();
      repeat (4) stepCycle("rst.after");
      checkEq("rst.no_release", 32'(cntRelease), 32'd0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      repeat (4) stepCycle("rst.drain");

      // Fall exactly at the LONG terminal count gives RELEASE only.
      clearCounts();
      applyStimulus(4'b0010, 1'b1, 1'b0);
      repeat (8) stepCycle("edge.hold");
      applyStimulus(4'b0000, 1'b1, 1'b0);
      repeat (4) stepCycle("edge.fall");
      checkEq("edge.long_cnt", 32'(cntLong), 32'd0);
      checkEq("edge.release_cnt", 32'(cntRelease), 32'd1);
      checkEq("edge.press_cnt", 32'(cntPress), 32'd1);

      // Randomised levels, backpressure and overflow clears.
      for (int c = 0; c < 1500; c++) begin
         logic [N-1:0] lvl;
         lvl = btnLevel;
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 11) == 0) lvl[i] = ~lvl[i];
         applyStimulus(lvl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
         stepCycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
